// File: rtl/marfifo_pkg.sv
// Shared constants and helpers for the multi-channel RX sample FIFO.
package marfifo_pkg;

    // Words the output side can hold outside the memory: BRAM read register + output register.
    localparam int PF_DEPTH = 2;

    // Width of a channel index; never narrower than one bit so single-channel builds stay legal.
    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/marfifo_rr_arb.sv
// Round-robin arbiter: one grant per cycle among the requesters, priority rotating past the winner.
module marfifo_rr_arb
    import marfifo_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = ch_bits(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic [N-1:0]  i_req,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_gnt_vld
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_cand;

    // Scan upward from the priority pointer and grant the first requester found.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        w_cand    = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = IW'((int'(r_ptr) + i) % N);
            if (i_en && !o_gnt_vld && i_req[w_cand]) begin
                o_gnt_vld     = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_gnt_idx     = w_cand;
            end
        end
    end

    // Priority moves to the channel after the one just granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (o_gnt_vld) begin
            r_ptr <= IW'((int'(o_gnt_idx) + 1) % N);
        end
    end

endmodule

// File: rtl/marfifo_mc.sv
// Multi-channel RX sample FIFO: per-channel holding registers feed a shared
// memory through a round-robin arbiter; a two-stage FWFT prefetch drains it.
module marfifo_mc
    import marfifo_pkg::*;
#(
    parameter int LENGTH       = 16384,
    parameter int WIDTH        = 24,
    parameter int CHANNELS     = 4,
    parameter int AFULL_THRESH = LENGTH - 64,
    localparam int CH_BITS     = ch_bits(CHANNELS),
    localparam int ADDR_BITS   = $clog2(LENGTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*WIDTH-1:0]    data_i,
    input  logic [CHANNELS-1:0]          valid_i,
    input  logic                         clear_i,
    input  logic                         clr_err_i,
    output logic [WIDTH-1:0]             data_o,
    output logic [CH_BITS-1:0]           chan_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [ADDR_BITS:0]           locs_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic                         afull_o,
    output logic [CHANNELS-1:0]          err_ovf_o
);

    localparam int CW = ADDR_BITS + 1;

    typedef struct packed {
        logic [CH_BITS-1:0] chan;
        logic [WIDTH-1:0]   data;
    } entry_t;

    // Input stage
    logic [WIDTH-1:0]    r_hold_data [CHANNELS];
    logic [CHANNELS-1:0] r_hold_vld;
    logic [CHANNELS-1:0] w_hold_take;
    logic [CHANNELS-1:0] w_accept;
    logic [CHANNELS-1:0] w_ovf;
    logic [CHANNELS-1:0] r_err;

    // Arbiter / memory
    logic [CHANNELS-1:0] w_gnt;
    logic [CH_BITS-1:0]  w_gnt_idx;
    logic                w_gnt_vld;
    logic                w_arb_en;
    entry_t              w_wr_entry;
    entry_t              r_mem [LENGTH];
    logic [CW-1:0]       r_wr_ptr;
    logic [CW-1:0]       r_rd_ptr;
    logic [CW-1:0]       w_mem_cnt;
    logic                w_mem_full;
    logic                w_mem_empty;

    // Prefetch
    entry_t              r_rd_q;
    logic                r_rd_vld;
    entry_t              r_out;
    logic                r_out_vld;
    logic                w_pop;
    logic                w_out_load;
    logic                w_rd_move;
    logic                w_rd_issue;

    // Status
    logic [CW-1:0]       w_cnt;
    logic [CW-1:0]       r_locs;
    logic                r_empty;
    logic                r_full;
    logic                r_afull;

    // A hold register is free if empty or being drained into memory on this edge.
    assign w_hold_take = ~r_hold_vld | w_gnt;
    assign w_accept    = valid_i & w_hold_take & {CHANNELS{~clear_i}};
    assign w_ovf       = valid_i & ~w_hold_take & {CHANNELS{~clear_i}};

    assign w_mem_cnt   = r_wr_ptr - r_rd_ptr;
    assign w_mem_full  = (w_mem_cnt == CW'(LENGTH));
    assign w_mem_empty = (w_mem_cnt == '0);
    assign w_arb_en    = !w_mem_full && !clear_i && !rst;

    assign w_pop       = r_out_vld && ready_i;
    assign w_out_load  = !r_out_vld || w_pop;
    assign w_rd_move   = r_rd_vld && w_out_load;
    assign w_rd_issue  = !w_mem_empty && (!r_rd_vld || w_rd_move);

    assign w_cnt = w_mem_cnt + CW'(r_rd_vld) + CW'(r_out_vld);

    marfifo_rr_arb #(.N(CHANNELS)) u_arb (
        .clk       (clk),
        .rst       (rst || clear_i),
        .i_en      (w_arb_en),
        .i_req     (r_hold_vld),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    // Select the granted channel's sample and tag it with its channel number.
    always_comb begin
        w_wr_entry      = '0;
        w_wr_entry.chan = w_gnt_idx;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_gnt[c]) begin
                w_wr_entry.data = r_hold_data[c];
            end
        end
    end

    // Holding-register occupancy: set on accept, cleared when the arbiter drains it.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            r_hold_vld <= '0;
        end else begin
            r_hold_vld <= (r_hold_vld & ~w_gnt) | w_accept;
        end
    end

    // Holding-register payloads; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_accept[c]) begin
                r_hold_data[c] <= data_i[c*WIDTH +: WIDTH];
            end
        end
    end

    // Sticky overflow flags; a new overflow wins over a same-cycle clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            r_err <= (clr_err_i ? '0 : r_err) | w_ovf;
        end
    end

    // Block RAM: one write port from the arbiter, registered read into the prefetch stage.
    always_ff @(posedge clk) begin
        if (w_gnt_vld) begin
            r_mem[r_wr_ptr[ADDR_BITS-1:0]] <= w_wr_entry;
        end
        if (w_rd_issue) begin
            r_rd_q <= r_mem[r_rd_ptr[ADDR_BITS-1:0]];
        end
    end

    // Pointers and the two prefetch stages; the output register only changes when empty or popped.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_vld  <= 1'b0;
            r_out_vld <= 1'b0;
            r_out     <= '0;
        end else begin
            if (w_gnt_vld) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_rd_vld <= 1'b1;
            end else if (w_rd_move) begin
                r_rd_vld <= 1'b0;
            end
            if (w_out_load) begin
                r_out_vld <= r_rd_vld;
                if (r_rd_vld) begin
                    r_out <= r_rd_q;
                end
            end
        end
    end

    // Registered occupancy flags, all derived from the same word count.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            r_locs  <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
        end else begin
            r_locs  <= w_cnt;
            r_empty <= (w_cnt == '0);
            r_full  <= w_mem_full;
            r_afull <= (int'(w_cnt) >= AFULL_THRESH);
        end
    end

    generate
        if (CHANNELS == 1) begin : g_one_chan
            assign chan_o = '0;
        end else begin : g_multi_chan
            assign chan_o = r_out.chan;
        end
    endgenerate

    assign data_o    = r_out.data;
    assign valid_o   = r_out_vld;
    assign locs_o    = r_locs;
    assign empty_o   = r_empty;
    assign full_o    = r_full;
    assign afull_o   = r_afull;
    assign err_ovf_o = r_err;

endmodule

// File: tb/tb_marfifo_mc.sv
// Self-checking bench for marfifo_mc: small memory so full and wrap are reachable.
module tb_marfifo_mc;
  import marfifo_pkg::*;

  localparam int LENGTH    = 16;
  localparam int WIDTH     = 24;
  localparam int CHANNELS  = 4;
  localparam int AFULL     = 12;
  localparam int CH_BITS   = 2;
  localparam int ADDR_BITS = 4;
  localparam int EW        = CH_BITS + WIDTH;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [CHANNELS*WIDTH-1:0] data_i;
  logic [CHANNELS-1:0]       valid_i;
  logic                      clear_i;
  logic                      clr_err_i;
  logic                      ready_i;
  logic [WIDTH-1:0]          data_o;
  logic [CH_BITS-1:0]        chan_o;
  logic                      valid_o;
  logic [ADDR_BITS:0]        locs_o;
  logic                      empty_o;
  logic                      full_o;
  logic                      afull_o;
  logic [CHANNELS-1:0]       err_ovf_o;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;
  int  n_vec = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;

  marfifo_mc #(
    .LENGTH(LENGTH), .WIDTH(WIDTH), .CHANNELS(CHANNELS), .AFULL_THRESH(AFULL)
  ) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .clear_i(clear_i),
    .clr_err_i(clr_err_i), .data_o(data_o), .chan_o(chan_o), .valid_o(valid_o),
    .ready_i(ready_i), .locs_o(locs_o), .empty_o(empty_o), .full_o(full_o),
    .afull_o(afull_o), .err_ovf_o(err_ovf_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // scoreboard: a handshake seen here completes on the next rising edge
  always @(negedge clk) begin
    if (mon_en && valid_o && ready_i) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_word unexpected: got chan=%0d data=%h, required no word", chan_o, data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({chan_o, data_o} !== mon_exp) begin
          n_err++;
          $display("FAIL out_word: got chan=%0d data=%h, required chan=%0d data=%h",
                   chan_o, data_o, mon_exp[EW-1 -: CH_BITS], mon_exp[WIDTH-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i   = '0;
    data_i    = '0;
    clear_i   = 1'b0;
    clr_err_i = 1'b0;
  endtask

  task automatic send(input int c, input logic [WIDTH-1:0] v, input bit push);
    valid_i[c] = 1'b1;
    data_i[c*WIDTH +: WIDTH] = v;
    if (push) exp_q.push_back({CH_BITS'(c), v});
  endtask

  task automatic do_reset();
    idle_inputs();
    ready_i = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    ready_i = 1'b1;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d words still outstanding, required 0", exp_q.size());
    end
    ready_i = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    n_vec += 8;
    if (valid_o !== 1'b0)   begin n_err++; $display("FAIL reset_valid: got %b required 0", valid_o); end
    if (data_o !== '0)      begin n_err++; $display("FAIL reset_data: got %h required 0", data_o); end
    if (chan_o !== '0)      begin n_err++; $display("FAIL reset_chan: got %0d required 0", chan_o); end
    if (locs_o !== '0)      begin n_err++; $display("FAIL reset_locs: got %0d required 0", locs_o); end
    if (empty_o !== 1'b1)   begin n_err++; $display("FAIL reset_empty: got %b required 1", empty_o); end
    if (full_o !== 1'b0)    begin n_err++; $display("FAIL reset_full: got %b required 0", full_o); end
    if (afull_o !== 1'b0)   begin n_err++; $display("FAIL reset_afull: got %b required 0", afull_o); end
    if (err_ovf_o !== '0)   begin n_err++; $display("FAIL reset_err: got %b required 0", err_ovf_o); end
  endtask

  task automatic test_single();
    do_reset();
    mon_en = 1'b1;
    send(2, 24'h000011, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) valid_i = '0;
      n_vec++;
      if (valid_o !== (k == 4)) begin
        n_err++; $display("FAIL single_latency edge+%0d: valid_o=%b required %b", k, valid_o, (k == 4));
      end
    end
    n_vec += 3;
    if (data_o !== 24'h000011) begin n_err++; $display("FAIL single_data: got %h required 000011", data_o); end
    if (chan_o !== 2'd2)       begin n_err++; $display("FAIL single_chan: got %0d required 2", chan_o); end
    if (locs_o !== 5'd1)       begin n_err++; $display("FAIL single_locs: got %0d required 1", locs_o); end
    ready_i = 1'b1;
    tick();
    n_vec += 2;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL single_pop_valid: got %b required 0", valid_o); end
    if (locs_o !== 5'd1)  begin n_err++; $display("FAIL single_locs_lag: got %0d required 1", locs_o); end
    tick();
    n_vec += 2;
    if (locs_o !== 5'd0)   begin n_err++; $display("FAIL single_locs_after: got %0d required 0", locs_o); end
    if (empty_o !== 1'b1)  begin n_err++; $display("FAIL single_empty_after: got %b required 1", empty_o); end
    ready_i = 1'b0;
  endtask

  task automatic test_all_channels();
    int cnt, first, last;
    do_reset();
    mon_en = 1'b1;
    ready_i = 1'b1;
    cnt = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      valid_i = '0;
      if (cyc % 4 == 0 && cyc < 24) begin
        for (int c = 0; c < CHANNELS; c++) send(c, {8'(cyc / 4), 8'hc0, 8'(c)}, 1'b1);
      end
      tick();
      if (valid_o) begin
        cnt++;
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    valid_i = '0;
    n_vec += 4;
    if (cnt !== 24) begin n_err++; $display("FAIL rr_count: got %0d words required 24", cnt); end
    if (last - first + 1 !== 24) begin
      n_err++; $display("FAIL rr_sustained: output span %0d cycles required 24", last - first + 1);
    end
    if (err_ovf_o !== '0) begin n_err++; $display("FAIL rr_err: got %b required 0", err_ovf_o); end
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL rr_left: %0d words outstanding required 0", exp_q.size()); end
    ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    mon_en = 1'b1;
    ready_i = 1'b1;
    for (int c = 0; c < CHANNELS; c++) send(c, 24'h002000 + 24'(c), 1'b1);
    tick();
    valid_i = '0;
    send(1, 24'h0002ff, 1'b0);
    tick();
    valid_i = '0;
    drain(30);
    n_vec++;
    if (err_ovf_o !== 4'b0010) begin n_err++; $display("FAIL ovf_flag: got %b required 0010", err_ovf_o); end
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    n_vec++;
    if (err_ovf_o !== 4'b0000) begin n_err++; $display("FAIL ovf_clear: got %b required 0000", err_ovf_o); end
    // overflow and clear on the same edge: the overflow must win
    ready_i = 1'b1;
    send(0, 24'h003000, 1'b1);
    send(1, 24'h003001, 1'b1);
    tick();
    valid_i = '0;
    send(1, 24'h0030ff, 1'b0);
    clr_err_i = 1'b1;
    tick();
    valid_i = '0;
    clr_err_i = 1'b0;
    n_vec++;
    if (err_ovf_o !== 4'b0010) begin n_err++; $display("FAIL ovf_set_wins: got %b required 0010", err_ovf_o); end
    drain(30);
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < LENGTH + PF_DEPTH; i++) begin
      valid_i = '0;
      send(i % 4, 24'h000100 + 24'(i), 1'b1);
      tick();
    end
    valid_i = '0;
    repeat (4) tick();
    n_vec += 4;
    if (full_o !== 1'b1)  begin n_err++; $display("FAIL full_flag: got %b required 1", full_o); end
    if (locs_o !== 5'(LENGTH + PF_DEPTH)) begin
      n_err++; $display("FAIL full_locs: got %0d required %0d", locs_o, LENGTH + PF_DEPTH);
    end
    if (afull_o !== 1'b1) begin n_err++; $display("FAIL full_afull: got %b required 1", afull_o); end
    if (empty_o !== 1'b0) begin n_err++; $display("FAIL full_empty: got %b required 0", empty_o); end
    send(0, 24'h000aaa, 1'b1);
    tick();
    valid_i = '0;
    send(0, 24'h000bbb, 1'b0);
    tick();
    valid_i = '0;
    tick();
    tick();
    n_vec += 2;
    if (err_ovf_o !== 4'b0001) begin n_err++; $display("FAIL full_drop_err: got %b required 0001", err_ovf_o); end
    if (locs_o !== 5'(LENGTH + PF_DEPTH)) begin
      n_err++; $display("FAIL full_locs_hold: got %0d required %0d", locs_o, LENGTH + PF_DEPTH);
    end
    drain(100);
    tick();
    n_vec += 3;
    if (locs_o !== 5'd0)  begin n_err++; $display("FAIL full_drained_locs: got %0d required 0", locs_o); end
    if (full_o !== 1'b0)  begin n_err++; $display("FAIL full_drained_full: got %b required 0", full_o); end
    if (empty_o !== 1'b1) begin n_err++; $display("FAIL full_drained_empty: got %b required 1", empty_o); end
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
  endtask

  task automatic test_wrap();
    int sent, cyc;
    bit seen_afull;
    do_reset();
    mon_en = 1'b1;
    sent = 0; cyc = 0; seen_afull = 1'b0;
    while ((sent < 3 * LENGTH || exp_q.size() != 0) && cyc < 3000) begin
      valid_i = '0;
      if (sent < 3 * LENGTH && !full_o && locs_o <= 5'd13 && $urandom_range(0, 1) == 1) begin
        send(sent % 4, 24'h300000 + 24'(sent), 1'b1);
        sent++;
      end
      ready_i = (sent < 3 * LENGTH) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 70);
      tick();
      cyc++;
      n_vec += 2;
      if (afull_o !== (locs_o >= 5'(AFULL))) begin
        n_err++; $display("FAIL wrap_afull: afull_o=%b with locs_o=%0d", afull_o, locs_o);
      end
      if (locs_o > 5'(LENGTH + PF_DEPTH)) begin
        n_err++; $display("FAIL wrap_locs_range: got %0d required <= %0d", locs_o, LENGTH + PF_DEPTH);
      end
      if (afull_o) seen_afull = 1'b1;
    end
    valid_i = '0;
    ready_i = 1'b0;
    tick();
    n_vec += 3;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL wrap_left: %0d words outstanding required 0", exp_q.size()); end
    if (seen_afull !== 1'b1) begin n_err++; $display("FAIL wrap_afull_seen: got %b required 1", seen_afull); end
    if (err_ovf_o !== '0) begin n_err++; $display("FAIL wrap_err: got %b required 0", err_ovf_o); end
  endtask

  task automatic test_rst_clear();
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid_i = '0;
      send(i % 4, 24'h000400 + 24'(i), 1'b0);
      tick();
    end
    for (int c = 0; c < CHANNELS; c++) send(c, 24'h0004f0 + 24'(c), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    valid_i = '0;
    n_vec += 8;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b required 0", valid_o); end
    if (data_o !== '0)    begin n_err++; $display("FAIL rst_mid_data: got %h required 0", data_o); end
    if (chan_o !== '0)    begin n_err++; $display("FAIL rst_mid_chan: got %0d required 0", chan_o); end
    if (locs_o !== '0)    begin n_err++; $display("FAIL rst_mid_locs: got %0d required 0", locs_o); end
    if (empty_o !== 1'b1) begin n_err++; $display("FAIL rst_mid_empty: got %b required 1", empty_o); end
    if (full_o !== 1'b0)  begin n_err++; $display("FAIL rst_mid_full: got %b required 0", full_o); end
    if (afull_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_afull: got %b required 0", afull_o); end
    if (err_ovf_o !== '0) begin n_err++; $display("FAIL rst_mid_err: got %b required 0", err_ovf_o); end
    send(2, 24'h000055, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) valid_i = '0;
      n_vec++;
      if (valid_o !== (k == 4)) begin
        n_err++; $display("FAIL rst_latency edge+%0d: valid_o=%b required %b", k, valid_o, (k == 4));
      end
    end
    // clear while words sit in memory, prefetch and the holding registers
    for (int i = 0; i < 5; i++) begin
      valid_i = '0;
      send(i % 4, 24'h000500 + 24'(i), 1'b0);
      tick();
    end
    for (int c = 0; c < CHANNELS; c++) send(c, 24'h000600 + 24'(c), 1'b0);
    tick();
    for (int c = 0; c < CHANNELS; c++) send(c, 24'h000700 + 24'(c), 1'b0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    valid_i = '0;
    exp_q.delete();
    n_vec += 4;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL clear_valid: got %b required 0", valid_o); end
    if (locs_o !== '0)    begin n_err++; $display("FAIL clear_locs: got %0d required 0", locs_o); end
    if (empty_o !== 1'b1) begin n_err++; $display("FAIL clear_empty: got %b required 1", empty_o); end
    if (err_ovf_o !== '0) begin n_err++; $display("FAIL clear_err: got %b required 0", err_ovf_o); end
    send(3, 24'h000066, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) valid_i = '0;
      n_vec++;
      if (valid_o !== (k == 4)) begin
        n_err++; $display("FAIL clear_latency edge+%0d: valid_o=%b required %b", k, valid_o, (k == 4));
      end
    end
    n_vec += 2;
    if (chan_o !== 2'd3)       begin n_err++; $display("FAIL clear_first_chan: got %0d required 3", chan_o); end
    if (data_o !== 24'h000066) begin n_err++; $display("FAIL clear_first_data: got %h required 000066", data_o); end
    drain(20);
  endtask

  // sequence and final report
  initial begin
    rst = 1'b1;
    ready_i = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_all_channels();
    test_overflow();
    test_full();
    test_wrap();
    test_rst_clear();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
